fpa_controller: RTL

- Sequencing FSM for the floating-point adder datapath.
- Accepts a start request and steps the datapath through load, align/add, exception check, and iterative normalization.
- Commits the result and reports completion or an error code.
- Sits between the top-level operand interface and the datapath. It drives every register enable and mux select; it reads the datapath's mantissa and exception status.

---
 rtl/fpa_controller_if.sv | 31 +++
 rtl/fpa_controller.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fpa_controller_if.sv
// Control/status bundle between the FP adder datapath and its sequencer.
// The datapath side is master; the controller is slave.
interface fpa_controller_if;
    logic       start;
    logic       add_except;
    logic       norm_except;
    logic [4:0] mant;
    logic       load_en;
    logic       add_en;
    logic       norm_en;
    logic       norm_load;
    logic       shift_right;
    logic       done_en;
    logic       busy;
    logic       done;
    logic       result_zero;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output start, add_except, norm_except, mant,
        input  load_en, add_en, norm_en, norm_load, shift_right,
        input  done_en, busy, done, result_zero, err, err_code
    );

    modport slave (
        input  start, add_except, norm_except, mant,
        output load_en, add_en, norm_en, norm_load, shift_right,
        output done_en, busy, done, result_zero, err, err_code
    );
endinterface

// File: rtl/fpa_controller.sv
// Sequencing FSM for the floating-point adder datapath.
// Steps load, add, exception check and iterative normalization.
module fpa_controller #(
    parameter int MAX_NORM_STEPS = 4,
    parameter int STEP_W         = 3
) (
    input logic             clk,
    input logic             clr,
    fpa_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_ACHK,
        S_NLOAD,
        S_NEVAL,
        S_COMMIT,
        S_FIN,
        S_EXCEPT
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] steps;
    logic              err_q;
    logic              zero_q;
    logic [1:0]        code_q;

    logic at_max;
    logic m_zero;
    logic m_off;
    logic ev_nex;
    logic ev_zero;
    logic ev_lim;
    logic ev_shift;

    // Normalization decision terms, mutually exclusive in priority order
    always_comb begin
        at_max   = (steps == STEP_W'(MAX_NORM_STEPS));
        m_zero   = (bus.mant == 5'd0);
        m_off    = bus.mant[4] | ~bus.mant[3];
        ev_nex   = bus.norm_except;
        ev_zero  = ~ev_nex & m_zero;
        ev_lim   = ~ev_nex & ~m_zero & m_off & at_max;
        ev_shift = ~ev_nex & ~m_zero & m_off & ~at_max;
    end

    // State sequencing plus sticky status flags
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= S_IDLE;
            steps  <= '0;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
            code_q <= 2'b00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        err_q  <= 1'b0;
                        zero_q <= 1'b0;
                        code_q <= 2'b00;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_ADD;
                S_ADD:  state <= S_ACHK;
                S_ACHK: begin
                    if (bus.add_except) begin
                        err_q  <= 1'b1;
                        code_q <= 2'b01;
                        state  <= S_EXCEPT;
                    end else begin
                        state <= S_NLOAD;
                    end
                end
                S_NLOAD: begin
                    steps <= '0;
                    state <= S_NEVAL;
                end
                S_NEVAL: begin
                    unique case (1'b1)
                        ev_nex: begin
                            err_q  <= 1'b1;
                            code_q <= 2'b10;
                            state  <= S_EXCEPT;
                        end
                        ev_zero: begin
                            zero_q <= 1'b1;
                            state  <= S_COMMIT;
                        end
                        ev_lim: begin
                            err_q  <= 1'b1;
                            code_q <= 2'b11;
                            state  <= S_EXCEPT;
                        end
                        // ev_shift already excludes at_max, so no wrap
                        ev_shift: steps <= steps + STEP_W'(1);
                        default:  state <= S_COMMIT;
                    endcase
                end
                S_COMMIT: state <= S_FIN;
                S_FIN:    state <= S_IDLE;
                S_EXCEPT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign bus.load_en     = (state == S_LOAD);
    assign bus.add_en      = (state == S_ADD);
    assign bus.norm_en     = (state == S_NLOAD)
                           | ((state == S_NEVAL) & ev_shift);
    assign bus.norm_load   = (state == S_NLOAD);
    assign bus.shift_right = (state == S_NEVAL) & ev_shift
                           & bus.mant[4];
    assign bus.done_en     = (state == S_COMMIT);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_FIN) | (state == S_EXCEPT);
    assign bus.result_zero = zero_q;
    assign bus.err         = err_q;
    assign bus.err_code    = code_q;
endmodule
